// File: rtl/tlv5618_rx.sv
// ---------------------------------------------------------------------------
// tlv5618_rx
//
// Receiver for the TLV5618 3-wire DAC serial interface. It synchronises
// cs_n/sclk/din into clk, shifts in 16 bits MSB first on sclk falling edges,
// and on every cs_n rising edge either applies the word to the DAC register
// model or flags a framing error.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// WAIT_HIGH | after reset; wait for cs_n high so a frame in flight is dropped
// IDLE      | between frames; a cs_n fall starts a new frame
// SHIFT     | collecting bits on sclk falls; a cs_n rise ends the frame
// COMMIT    | one cycle: apply a good 16-bit word or pulse frame_err
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   DAC_cs_n   in   frame select, active low (async to clk)
//   DAC_sclk   in   serial clock (async to clk)
//   DAC_din    in   serial data, MSB first
//   rx_word    out  last correctly framed word
//   word_valid out  one-cycle pulse when rx_word updates
//   frame_err  out  one-cycle pulse on a mis-framed cs_n rise
//   dac_a      out  DAC A output latch
//   dac_b      out  DAC B output latch
//   dac_buf    out  double-buffer latch
//   fast_mode  out  SPD bit of the last valid word
//   power_down out  PWR bit of the last valid word
// ---------------------------------------------------------------------------
module tlv5618_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        DAC_cs_n,
    input  logic        DAC_sclk,
    input  logic        DAC_din,
    output logic [15:0] rx_word,
    output logic        word_valid,
    output logic        frame_err,
    output logic [11:0] dac_a,
    output logic [11:0] dac_b,
    output logic [11:0] dac_buf,
    output logic        fast_mode,
    output logic        power_down
);

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   cs_hist;
    logic                   sclk_hist;

    logic [15:0] shreg;
    logic [4:0]  bit_cnt;

    logic cs_s;
    logic sclk_s;
    logic din_s;
    logic cs_fall;
    logic cs_rise;
    logic sclk_fall;

    // Synchroniser chains reset to 0. A low cs_n reset value keeps WAIT_HIGH
    // from seeing a false "high" while the chain refills after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            din_sync  <= '0;
            cs_hist   <= 1'b0;
            sclk_hist <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], DAC_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], DAC_sclk};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], DAC_din};
            cs_hist   <= cs_sync[SYNC_STAGES-1];
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_hist & ~cs_s;
    assign cs_rise   = ~cs_hist & cs_s;
    assign sclk_fall = sclk_hist & ~sclk_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_HIGH;
            shreg      <= '0;
            bit_cnt    <= '0;
            rx_word    <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            dac_a      <= '0;
            dac_b      <= '0;
            dac_buf    <= '0;
            fast_mode  <= 1'b0;
            power_down <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                WAIT_HIGH: begin
                    if (cs_s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (cs_fall) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cs_n rise wins over a coincident sclk fall.
                    if (cs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_fall) begin
                        shreg <= {shreg[14:0], din_s};
                        // Saturate at 17 so any over-long frame stays invalid.
                        if (bit_cnt != 5'd17) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                COMMIT: begin
                    if (bit_cnt == 5'd16) begin
                        rx_word    <= shreg;
                        fast_mode  <= shreg[14];
                        power_down <= shreg[13];
                        word_valid <= 1'b1;
                        case ({shreg[15], shreg[12]})
                            2'b00: begin
                                dac_b   <= shreg[11:0];
                                dac_buf <= shreg[11:0];
                            end
                            2'b01: begin
                                dac_buf <= shreg[11:0];
                            end
                            2'b10: begin
                                dac_a <= shreg[11:0];
                                dac_b <= dac_buf;
                            end
                            default: begin
                            end
                        endcase
                    end else begin
                        frame_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= WAIT_HIGH;
            endcase
        end
    end

endmodule

// File: tb/tb_tlv5618_rx.sv
`timescale 1ns/1ps
module tb_tlv5618_rx;

    localparam int SS = 2;
    localparam int PH = SS + 2;

    logic        clk;
    logic        rst_n;
    logic        cs_n;
    logic        sclk;
    logic        din;
    logic [15:0] rx_word;
    logic        word_valid;
    logic        frame_err;
    logic [11:0] dac_a;
    logic [11:0] dac_b;
    logic [11:0] dac_buf;
    logic        fast_mode;
    logic        power_down;

    tlv5618_rx #(.SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .DAC_cs_n   (cs_n),
        .DAC_sclk   (sclk),
        .DAC_din    (din),
        .rx_word    (rx_word),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .dac_a      (dac_a),
        .dac_b      (dac_b),
        .dac_buf    (dac_buf),
        .fast_mode  (fast_mode),
        .power_down (power_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [15:0] rx;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] bf;
        logic        fm;
        logic        pd;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int wv_cnt  = 0;
    int fe_cnt  = 0;

    logic [15:0] m_rx;
    logic [11:0] m_a, m_b, m_bf;
    logic        m_fm, m_pd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        m_rx = '0; m_a = '0; m_b = '0; m_bf = '0; m_fm = 1'b0; m_pd = 1'b0;
    endtask

    task automatic push_cur(input logic err);
        exp_t e;
        e.err = err; e.rx = m_rx; e.a = m_a; e.b = m_b; e.bf = m_bf;
        e.fm = m_fm; e.pd = m_pd;
        exp_q.push_back(e);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b);
        din  = b;
        sclk = 1'b1;
        wait_clk(PH);
        sclk = 1'b0;
        wait_clk(PH);
    endtask

    task automatic raw_frame(input logic [16:0] pat, input int n);
        cs_n = 1'b0;
        wait_clk(PH);
        for (int i = n - 1; i >= 0; i--) clk_bit(pat[i]);
        cs_n = 1'b1;
        wait_clk(12);
    endtask

    task automatic good_frame(input logic [15:0] w);
        logic [11:0] d;
        d = w[11:0];
        case ({w[15], w[12]})
            2'b00: begin m_b = d; m_bf = d; end
            2'b01: begin m_bf = d; end
            2'b10: begin m_b = m_bf; m_a = d; end
            default: ;
        endcase
        m_rx = w; m_fm = w[14]; m_pd = w[13];
        push_cur(1'b0);
        raw_frame({1'b0, w}, 16);
    endtask

    task automatic bad_frame(input logic [16:0] pat, input int n);
        push_cur(1'b1);
        raw_frame(pat, n);
    endtask

    // Scoreboard: every pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n && (word_valid || frame_err)) begin
            exp_t e;
            if (word_valid) wv_cnt++;
            if (frame_err)  fe_cnt++;
            chk("pulse_excl", {31'd0, word_valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexp_pulse", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_kind",  {31'd0, frame_err}, {31'd0, e.err});
                chk("sb_rx",    {16'd0, rx_word}, {16'd0, e.rx});
                chk("sb_dac_a", {20'd0, dac_a},   {20'd0, e.a});
                chk("sb_dac_b", {20'd0, dac_b},   {20'd0, e.b});
                chk("sb_buf",   {20'd0, dac_buf}, {20'd0, e.bf});
                chk("sb_fm",    {31'd0, fast_mode},  {31'd0, e.fm});
                chk("sb_pd",    {31'd0, power_down}, {31'd0, e.pd});
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx"},  {16'd0, rx_word}, 32'd0);
        chk({tag, "_a"},   {20'd0, dac_a},   32'd0);
        chk({tag, "_b"},   {20'd0, dac_b},   32'd0);
        chk({tag, "_buf"}, {20'd0, dac_buf}, 32'd0);
        chk({tag, "_fmpd"}, {30'd0, fast_mode, power_down}, 32'd0);
        chk({tag, "_pulse"}, {30'd0, word_valid, frame_err}, 32'd0);
    endtask

    initial begin
        int guard;
        model_clear();
        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; din = 1'b0;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);
        chk_all_zero("reset");

        // R1R0 = 00
        good_frame(16'h0ABC);
        chk("t1_b",   {20'd0, dac_b},   32'hABC);
        chk("t1_buf", {20'd0, dac_buf}, 32'hABC);
        chk("t1_a",   {20'd0, dac_a},   32'h0);
        chk("t1_rx",  {16'd0, rx_word}, 32'h0ABC);
        chk("t1_wv",  wv_cnt, 1);

        // R1R0 = 01 then 10
        good_frame(16'h1123);
        chk("t2_buf", {20'd0, dac_buf}, 32'h123);
        chk("t2_b",   {20'd0, dac_b},   32'hABC);
        good_frame(16'h8456);
        chk("t2_a",   {20'd0, dac_a},   32'h456);
        chk("t2_b2",  {20'd0, dac_b},   32'h123);

        // SPD/PWR and reserved select
        good_frame(16'h7FFF);
        chk("t3_fm",  {31'd0, fast_mode},  32'd1);
        chk("t3_pd",  {31'd0, power_down}, 32'd1);
        chk("t3_buf", {20'd0, dac_buf}, 32'hFFF);
        good_frame(16'h9000);
        chk("t3_fm0", {31'd0, fast_mode},  32'd0);
        chk("t3_pd0", {31'd0, power_down}, 32'd0);
        chk("t3_rx",  {16'd0, rx_word}, 32'h9000);
        chk("t3_a",   {20'd0, dac_a},   32'h456);
        chk("t3_b",   {20'd0, dac_b},   32'h123);
        chk("t3_buf2",{20'd0, dac_buf}, 32'hFFF);

        // Mis-framed: 15 and 17 edges
        bad_frame(17'h00ABC, 15);
        bad_frame(17'h1A5A5, 17);
        chk("t4_fe", fe_cnt, 2);
        chk("t4_wv", wv_cnt, 5);
        chk("t4_rx", {16'd0, rx_word}, 32'h9000);
        chk("t4_b",  {20'd0, dac_b},   32'h123);

        // cs_n low across reset release
        rst_n = 1'b0;
        cs_n  = 1'b0;
        wait_clk(3);
        model_clear();
        rst_n = 1'b1;
        wait_clk(PH);
        for (int i = 0; i < 8; i++) clk_bit(1'b1);
        cs_n = 1'b1;
        wait_clk(12);
        good_frame(16'h0001);
        chk("t5_b",  {20'd0, dac_b}, 32'h001);
        chk("t5_fe", fe_cnt, 2);
        chk("t5_wv", wv_cnt, 6);

        // Reset mid-frame
        cs_n = 1'b0;
        wait_clk(PH);
        for (int i = 0; i < 10; i++) clk_bit(i[0]);
        rst_n = 1'b0;
        wait_clk(2);
        chk_all_zero("t6_rst");
        model_clear();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) clk_bit(1'b1);
        cs_n = 1'b1;
        wait_clk(12);
        chk("t6_wv_none", wv_cnt, 6);
        good_frame(16'h0055);
        chk("t6_b",   {20'd0, dac_b},   32'h055);
        chk("t6_buf", {20'd0, dac_buf}, 32'h055);
        chk("t6_a",   {20'd0, dac_a},   32'h0);
        chk("t6_rx",  {16'd0, rx_word}, 32'h0055);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            wait_clk(1);
            guard++;
        end
        chk("sb_drain", exp_q.size(), 0);
        chk("final_wv", wv_cnt, 7);
        chk("final_fe", fe_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
